// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the FSM state encoding, the byte-lane count per word and the nop word.
`timescale 1ns/1ps
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Instruction RAM: one synchronous write port, one combinational read port, no reset.
// Read latency zero; write visible after the writing edge; no backpressure.
`timescale 1ns/1ps
module imem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into the instruction RAM and holds the core in reset until loaded.
// instr is combinational from pc; rx_ready_o depends on state only, one byte per cycle max.
`timescale 1ns/1ps
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        load_start_i,
  input  logic [AW:0] load_len_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        core_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [23:0]   shift_q, shift_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          core_reset_q, core_reset_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          len_legal;
  logic          last_word;
  logic          pc_out_of_range;
  logic          unused_pc_lsb;

  assign len_legal = (load_len_i != '0) && (load_len_i <= DEPTH_LEN);
  assign last_word = ({1'b0, word_cnt_q} == (len_q - (AW+1)'(1)));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_reset_q <= core_reset_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    shift_d      = shift_q;
    done_d       = done_q;
    err_d        = err_q;
    core_reset_d = core_reset_q;
    ram_we       = 1'b0;
    ram_waddr    = word_cnt_q;
    ram_wdata    = {shift_q, rx_data_i};

    unique case (state_q)
      IDLE, RUN: begin
        if (load_start_i) begin
          core_reset_d = 1'b1;
          done_d       = 1'b0;
          if (len_legal) begin
            len_d      = load_len_i;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            err_d      = 1'b0;
            state_d    = LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LOAD: begin
        // rx_ready is constant in LOAD, so rx_valid alone marks a transfer.
        if (rx_valid_i) begin
          if (byte_cnt_q == LAST_BYTE) begin
            ram_we     = 1'b1;
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (last_word) begin
              state_d      = RUN;
              done_d       = 1'b1;
              core_reset_d = 1'b0;
            end
          end else begin
            shift_d    = {shift_q[15:0], rx_data_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (pc_i[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  // Fetches past the RAM fall through to a nop rather than aliasing.
  assign pc_out_of_range = (pc_i[31:AW+2] != '0);
  assign unused_pc_lsb   = ^pc_i[1:0];

  assign instr_o      = pc_out_of_range ? NOP_INSTR : ram_rdata;
  assign rx_ready_o   = (state_q == LOAD);
  assign busy_o       = (state_q == LOAD);
  assign core_reset_o = core_reset_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory and loader on the fetch side of the single-cycle `mips` core. It receives a program as a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It stores the words in an internal instruction RAM and holds the core in reset until the load completes. In RUN it serves `instr` combinationally from the core's `pc`, as the single-cycle datapath requires.

## Interface
Parameters:
- `DEPTH`, 64: instruction RAM size in 32-bit words; power of two, 4..1024.
- `AW`, `$clog2(DEPTH)`: derived word-address width; not overridden.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `load_start`  in  1  one-cycle request to begin a program load.
- `load_len`  in  AW+1  number of words to load; sampled only when `load_start`=1.
- `rx_data`  in  8  program byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `pc`  in  32  core program counter.
- `instr`  out  32  instruction at `pc`.
- `core_reset`  out  1  active-high reset to the `mips` core.
- `busy`  out  1  high in LOAD.
- `done`  out  1  last load completed; sticky.
- `err`  out  1  last `load_start` had an illegal `load_len`; sticky.

## Operation
States: IDLE, LOAD, RUN.

- **Reset** (`reset`=0, takes effect asynchronously):
  - Go to IDLE.
  - `core_reset`=1, `rx_ready`=0, `busy`=0, `done`=0, `err`=0.
  - Byte counter and word counter cleared.
  - RAM contents are not cleared.
- **IDLE**, `load_start`=1:
  - If 1 ≤ `load_len` ≤ DEPTH: latch the length, clear counters, `done`=0, `err`=0, go to LOAD.
  - Otherwise: `err`=1, `done`=0, stay in IDLE.
- **LOAD**:
  - `rx_ready`=1, `busy`=1, `core_reset`=1.
  - A transfer occurs on any cycle with `rx_valid`&&`rx_ready`.
  - Bytes 0..3 of each word fill bits [31:24], [23:16], [15:8], [7:0] in that order.
  - The 4th byte writes the assembled word to RAM[word counter] at the same edge and increments the word counter.
  - `load_start` is ignored in LOAD.
- **LOAD→RUN**: taken at the edge that writes word `load_len`-1. From that edge: `done`=1, `busy`=0, `rx_ready`=0, `core_reset`=0.
- **RUN**:
  - `load_start` with a legal length behaves as from IDLE and reasserts `core_reset` from the next edge.
  - `load_start` with an illegal length sets `err`=1, returns to IDLE and reasserts `core_reset`.
  - Words beyond the new `load_len` keep their old contents.
- **Read path**:
  - `instr` = RAM[`pc`[AW+1:2]], combinational, in every state.
  - `pc`[1:0] is ignored.
  - If `pc`[31:AW+2] ≠ 0, `instr` = 32'h0000_0000 (`sll $0,$0,0`, a nop).
- **Partial word**: if a new load begins, by reset or by `load_start` from RUN, the byte counter is discarded and the partial word is never written.

## Timing
- Byte throughput: one byte per cycle maximum, so one word per 4 cycles and a minimum load of 4×`load_len` cycles.
- `rx_ready` depends only on state, never on `rx_valid`, so there is no combinational valid→ready path.
- RAM write is synchronous. A word written at edge N is visible on `instr` after edge N.
- `instr` has zero-cycle latency from `pc`.
- `core_reset` is registered except for the asynchronous assertion on `reset`. It deasserts at the same edge that sets `done`.
- Stalls: a `rx_valid`=0 cycle in LOAD changes nothing.

## Structure
- Package `imem_loader_pkg` holds:
  - the state typedef (`IDLE`, `LOAD`, `RUN`);
  - byte-lane constants (`BYTES_PER_WORD`=4);
  - the nop constant (32'h0).
- Sub-module `imem_array`:
  - `DEPTH`×32 storage;
  - one synchronous write port (`we`, `waddr`, `wdata`);
  - one asynchronous read port (`raddr`, `rdata`);
  - no reset.
- The top level holds the FSM, byte/word counters, the word shift register and the out-of-range `pc` mux.

## Test plan
- Reset low for 3 cycles, then high → `core_reset`=1, `rx_ready`=0, `done`=0, `err`=0, state IDLE.
- `load_len`=2, bytes 20 02 00 05 / 20 03 00 0C, streamed back-to-back → RAM[0]=32'h2002_0005, RAM[1]=32'h2003_000C. `done`=1 and `core_reset`=0 at the edge after byte 8. Then `pc`=4 → `instr`=32'h2003_000C.
- Same load with `rx_valid` toggled every other cycle → identical RAM contents; `done` after 16 cycles.
- `load_start` with `load_len`=0 and again with DEPTH+1 → `err`=1 each time, `core_reset` stays 1, state stays IDLE. A following legal load clears `err`.
- `reset` asserted after 6 bytes of a 2-word load → immediate IDLE. RAM[0] keeps its loaded word and RAM[1] is unchanged.
- In RUN, `pc`=32'h0000_0400 with DEPTH=64 → `instr`=0. `load_start` with `load_len`=1 → `core_reset`=1 next cycle, and only RAM[0] is rewritten.
